// File: rtl/sort_host.sv
// Host-side driver for an 8-entry selection-sort engine: loads a frame, kicks the sorter,
// waits for completion under a timeout, then streams the sorted words out.
module sort_host #(
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 8,
    parameter int AW      = 3,
    parameter int TIMEOUT = 1024
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [WIDTH-1:0] i_in_data,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_out_data,
    output logic             o_out_last,
    output logic             o_s_wr,
    output logic             o_s_start,
    output logic [AW-1:0]    o_s_addr,
    output logic [WIDTH-1:0] o_s_datain,
    input  logic             i_s_ready,
    input  logic [WIDTH-1:0] i_s_dataout,
    output logic             o_err
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        ST_LOAD, ST_KICK, ST_BUSY, ST_DONE, ST_RADDR, ST_RCAP, ST_OUT, ST_HALT
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [AW-1:0]    r_wcnt;
    logic [AW-1:0]    r_rcnt;
    logic [TW-1:0]    r_tcnt;
    logic             r_s_wr;
    logic             r_s_start;
    logic [AW-1:0]    r_s_addr;
    logic [WIDTH-1:0] r_s_datain;
    logic             r_out_valid;
    logic             r_out_last;
    logic [WIDTH-1:0] r_out_data;
    logic             r_err;

    logic w_in_fire;
    logic w_wlast;
    logic w_rlast;
    logic w_timeout;

    assign o_in_ready = (r_state == ST_LOAD) && !i_rst;
    assign w_in_fire  = i_in_valid && o_in_ready;
    assign w_wlast    = (r_wcnt == AW'(DEPTH - 1));
    assign w_rlast    = (r_rcnt == AW'(DEPTH - 1));
    assign w_timeout  = (r_tcnt == TW'(TIMEOUT - 1));

    assign o_s_wr      = r_s_wr;
    assign o_s_start   = r_s_start;
    assign o_s_addr    = r_s_addr;
    assign o_s_datain  = r_s_datain;
    assign o_out_valid = r_out_valid;
    assign o_out_last  = r_out_last;
    assign o_out_data  = r_out_data;
    assign o_err       = r_err;

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= ST_LOAD;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_LOAD:  if (w_in_fire && w_wlast) w_next = ST_KICK;
            ST_KICK:  if (i_s_ready) w_next = ST_BUSY;
            ST_BUSY: begin
                if (w_timeout)       w_next = ST_HALT;
                else if (!i_s_ready) w_next = ST_DONE;
            end
            ST_DONE: begin
                if (w_timeout)      w_next = ST_HALT;
                else if (i_s_ready) w_next = ST_RADDR;
            end
            ST_RADDR: w_next = ST_RCAP;
            ST_RCAP:  w_next = ST_OUT;
            ST_OUT:   if (i_out_ready) w_next = w_rlast ? ST_LOAD : ST_RADDR;
            ST_HALT:  w_next = ST_HALT;
            default:  w_next = ST_LOAD;
        endcase
    end

    // Write/start strobes default low each cycle so they are single-cycle pulses.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wcnt      <= '0;
            r_rcnt      <= '0;
            r_tcnt      <= '0;
            r_s_wr      <= 1'b0;
            r_s_start   <= 1'b0;
            r_s_addr    <= '0;
            r_s_datain  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_data  <= '0;
            r_err       <= 1'b0;
        end else begin
            r_s_wr    <= 1'b0;
            r_s_start <= 1'b0;
            case (r_state)
                ST_LOAD: begin
                    if (w_in_fire) begin
                        r_s_wr     <= 1'b1;
                        r_s_addr   <= r_wcnt;
                        r_s_datain <= i_in_data;
                        r_wcnt     <= w_wlast ? '0 : r_wcnt + 1'b1;
                    end
                end
                ST_KICK: begin
                    if (i_s_ready) begin
                        r_s_start <= 1'b1;
                        r_tcnt    <= '0;
                    end
                end
                ST_BUSY, ST_DONE: begin
                    r_tcnt <= r_tcnt + 1'b1;
                    if (w_timeout) r_err <= 1'b1;
                end
                ST_RADDR: r_s_addr <= r_rcnt;
                ST_RCAP: begin
                    r_out_data  <= i_s_dataout;
                    r_out_valid <= 1'b1;
                    r_out_last  <= w_rlast;
                end
                ST_OUT: begin
                    if (i_out_ready) begin
                        r_out_valid <= 1'b0;
                        r_out_last  <= 1'b0;
                        r_rcnt      <= w_rlast ? '0 : r_rcnt + 1'b1;
                    end
                end
                ST_HALT: r_out_valid <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule
